// File: rtl/seg7_pkg.sv
// ============================================================================
// seg7_pkg: glyph table, blank pattern and digit count shared by the seven-
// segment encoder and scan decoder. Revision: 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low glyphs, bit0=a ... bit6=g
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_HELD  = 2'd2
  } dwell_state_t;

endpackage

`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
// ============================================================================
// seg7_pattern_decode: active-low segment pattern to {legal, nibble}; the
// inverse of the hex-to-segment encoder table. Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       legal,
  output logic [3:0] nibble
);

  // Anything outside the glyph table, SEG_BLANK included, decodes as illegal/0.
  always_comb begin
    legal  = 1'b1;
    nibble = 4'h0;
    case (pattern)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: legal  = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
// ============================================================================
// seg7_scan_decoder: recovers the 4-digit hex value from a multiplexed
// active-low seven-segment bus, accepting digits after a stable dwell.
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_n,
  input  logic [3:0]  an_n,
  output logic [15:0] value,
  output logic        value_valid,
  output logic [3:0]  digit_err
);

  localparam logic [7:0] c_stable = 8'(STABLE_CYCLES);
  localparam logic [7:0] c_accept = 8'(STABLE_CYCLES - 1);

  logic [6:0]   r_seg_s1, r_seg_s2, r_seg_prev;
  logic [3:0]   r_an_s1, r_an_s2, r_an_prev;
  logic [7:0]   r_cnt;
  logic [15:0]  r_buf;
  logic [3:0]   r_seen, r_err;
  dwell_state_t r_state, w_state_next;

  logic [3:0]   w_an_lo;
  logic         w_one_hot, w_same, w_accept, w_legal, w_frame_done;
  logic [7:0]   w_cnt_next;
  logic [1:0]   w_digit;
  logic [3:0]   w_nibble, w_seen_next, w_err_next;
  logic [15:0]  w_buf_next;

  seg7_pattern_decode u_decode (
    .pattern (r_seg_s2),
    .legal   (w_legal),
    .nibble  (w_nibble)
  );

  assign w_an_lo   = ~r_an_s2;
  assign w_one_hot = (w_an_lo != 4'd0) && ((w_an_lo & (w_an_lo - 4'd1)) == 4'd0);
  assign w_same    = (r_seg_s2 == r_seg_prev) && (r_an_s2 == r_an_prev);

  // w_cnt_next is "cycles stable so far minus one", so hitting c_accept
  // means the pair has been stable for exactly STABLE_CYCLES cycles.
  always_comb begin
    w_cnt_next = 8'd0;
    if (w_one_hot && w_same)
      w_cnt_next = (r_cnt == c_stable) ? r_cnt : r_cnt + 8'd1;
  end

  assign w_accept = w_one_hot && (r_state != ST_HELD) && (w_cnt_next == c_accept);

  always_comb begin
    w_state_next = r_state;
    if (!w_one_hot || !w_same)
      w_state_next = ST_IDLE;
    else if (w_accept)
      w_state_next = ST_HELD;
    else if (r_state != ST_HELD)
      w_state_next = ST_DWELL;
  end

  always_comb begin
    w_digit = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (w_an_lo[i]) w_digit = 2'(i);
  end

  always_comb begin
    w_buf_next  = r_buf;
    w_seen_next = r_seen;
    w_err_next  = r_err;
    if (w_accept) begin
      w_buf_next[{w_digit, 2'b00} +: 4] = w_nibble;
      w_seen_next[w_digit]              = 1'b1;
      w_err_next[w_digit]               = ~w_legal;
    end
  end

  assign w_frame_done = w_accept && (w_seen_next == 4'hF);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg_s1    <= '1;
      r_seg_s2    <= '1;
      r_seg_prev  <= '1;
      r_an_s1     <= '1;
      r_an_s2     <= '1;
      r_an_prev   <= '1;
      r_cnt       <= 8'd0;
      r_buf       <= 16'h0;
      r_seen      <= 4'h0;
      r_err       <= 4'h0;
      value       <= 16'h0;
      value_valid <= 1'b0;
      digit_err   <= 4'h0;
    end else begin
      r_seg_s1    <= seg_n;
      r_seg_s2    <= r_seg_s1;
      r_seg_prev  <= r_seg_s2;
      r_an_s1     <= an_n;
      r_an_s2     <= r_an_s1;
      r_an_prev   <= r_an_s2;
      r_cnt       <= w_cnt_next;
      r_buf       <= w_buf_next;
      value_valid <= w_frame_done;
      if (w_frame_done) begin
        value     <= w_buf_next;
        digit_err <= w_err_next;
        r_seen    <= 4'h0;
        r_err     <= 4'h0;
      end else begin
        r_seen    <= w_seen_next;
        r_err     <= w_err_next;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
// ============================================================================
// tb_seg7_scan_decoder: directed and random dwell sequences checked against a
// dwell-level reference model of the scan decoder. Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  an_n = 4'hF;
  logic [15:0] value;
  logic        value_valid;
  logic [3:0]  digit_err;

  seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .value       (value),
    .value_valid (value_valid),
    .digit_err   (digit_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: glyph table written out independently, active-low gfedcba.
  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [15:0] val;
    logic [3:0]  err;
    int          at;
  } frame_t;

  frame_t      exp_q[$];
  logic [3:0]  m_nib [4];
  bit          m_seen[4];
  bit          m_err [4];
  logic [3:0]  m_last_an  = 4'hF;
  logic [6:0]  m_last_seg = 7'h7F;
  int          m_run = S + 1;
  int          m_run_start = 0;
  logic [15:0] m_last_value = 16'h0;
  logic [3:0]  m_last_err = 4'h0;

  function automatic bit is_one_hot_low(input logic [3:0] an);
    return $countones(~an) == 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_seen[i] = 0;
      m_err[i]  = 0;
      m_nib[i]  = 4'h0;
    end
    m_last_an    = 4'hF;
    m_last_seg   = 7'h7F;
    m_run        = S + 1;
    m_last_value = 16'h0;
    m_last_err   = 4'h0;
  endtask

  task automatic model_accept(input logic [3:0] an, input logic [6:0] seg, input int start);
    int k = 0;
    int nib = -1;
    frame_t f;
    for (int i = 0; i < 4; i++) if (!an[i]) k = i;
    for (int g = 0; g < 16; g++) if (glyph[g] == seg) nib = g;
    m_nib[k]  = (nib < 0) ? 4'h0 : 4'(nib);
    m_err[k]  = (nib < 0);
    m_seen[k] = 1;
    if (m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3]) begin
      f.val = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
      f.err = {m_err[3], m_err[2], m_err[1], m_err[0]};
      f.at  = start + S + 2;
      exp_q.push_back(f);
      m_last_value = f.val;
      m_last_err   = f.err;
      for (int i = 0; i < 4; i++) begin
        m_seen[i] = 0;
        m_err[i]  = 0;
      end
    end
  endtask

  // Called #1 after a rising edge; holds the pair for len cycles.
  task automatic drive_dwell(input logic [3:0] an, input logic [6:0] seg, input int len);
    int prev;
    if (an == m_last_an && seg == m_last_seg) begin
      prev  = m_run;
      m_run = m_run + len;
    end else begin
      prev        = 0;
      m_run       = len;
      m_run_start = cyc;
      m_last_an   = an;
      m_last_seg  = seg;
    end
    if (m_run > S + 1) m_run = S + 1;
    if (is_one_hot_low(an) && prev < S && m_run >= S)
      model_accept(an, seg, m_run_start);
    an_n  = an;
    seg_n = seg;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic settle(input string tag);
    drive_dwell(4'hF, 7'h7F, S + 4);
    check({tag, "_value"}, value, m_last_value);
    check({tag, "_err"}, digit_err, m_last_err);
  endtask

  task automatic do_reset();
    drive_dwell(4'hF, 7'h7F, S + 4);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", value, 16'h0);
    check("rst_valid", value_valid, 1'b0);
    check("rst_err", digit_err, 4'h0);
    rst_n = 1'b1;
    model_reset();
  endtask

  always @(negedge clk) begin
    if (rst_n && value_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", value_valid, 1'b0);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        check("frame_value", value, e.val);
        check("frame_err", digit_err, e.err);
        check("frame_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Scan 1,2,3,4
    drive_dwell(4'b1110, glyph[1], 8);
    drive_dwell(4'b1101, glyph[2], 8);
    drive_dwell(4'b1011, glyph[3], 8);
    drive_dwell(4'b0111, glyph[4], 8);
    settle("scan1234");

    // Blank on digit 2
    drive_dwell(4'b1110, glyph[5], 8);
    drive_dwell(4'b1101, glyph[6], 8);
    drive_dwell(4'b1011, 7'h7F, 8);
    drive_dwell(4'b0111, glyph[8], 8);
    settle("blank");

    // Short glitch then A,B,C,D
    drive_dwell(4'b1110, glyph[9], S - 1);
    drive_dwell(4'b1110, glyph[10], 8);
    drive_dwell(4'b1101, glyph[11], 8);
    drive_dwell(4'b1011, glyph[12], 8);
    drive_dwell(4'b0111, glyph[13], 8);
    settle("glitch");

    // Two anodes low: nothing accepted
    drive_dwell(4'b1100, glyph[3], 20);
    settle("two_low");

    // Re-scan digit 0
    drive_dwell(4'b1110, glyph[5], 8);
    drive_dwell(4'b1110, glyph[7], 8);
    drive_dwell(4'b1101, glyph[0], 8);
    drive_dwell(4'b1011, glyph[0], 8);
    drive_dwell(4'b0111, glyph[0], 8);
    settle("rescan");

    // Reset with a partial frame pending
    drive_dwell(4'b1110, glyph[1], 8);
    drive_dwell(4'b1101, glyph[1], 8);
    do_reset();
    drive_dwell(4'b1110, glyph[15], 8);
    drive_dwell(4'b1101, glyph[14], 8);
    drive_dwell(4'b1011, glyph[13], 8);
    drive_dwell(4'b0111, glyph[12], 8);
    settle("post_reset");

    // Exactly S and S-1 cycle dwells
    drive_dwell(4'b1110, glyph[2], S);
    drive_dwell(4'b1101, glyph[3], S - 1);
    drive_dwell(4'b1101, glyph[4], S);
    drive_dwell(4'b1011, glyph[5], S);
    drive_dwell(4'b0111, glyph[6], S);
    settle("exact_dwell");

    // Random dwells
    for (int n = 0; n < 500; n++) begin
      int          cat;
      int          len;
      logic [3:0]  an;
      logic [6:0]  seg;
      cat = $urandom_range(0, 9);
      an  = ~(4'b0001 << $urandom_range(0, 3));
      seg = glyph[$urandom_range(0, 15)];
      if (cat == 7) seg = ($urandom_range(0, 1) == 1) ? 7'h7F : 7'($urandom);
      if (cat >= 8) an = 4'($urandom);
      len = $urandom_range(1, S + 4);
      drive_dwell(an, seg, len);
    end
    settle("random_end");
    check("pending_frames", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Reads a time-multiplexed, active-low 4-digit seven-segment display bus and recovers the hexadecimal value being shown. It is the decoding end of the team's hex-to-segment encoder path. It sits on board test and loopback paths, where it checks that a display driver emits the intended digits. Input is sampled through synchronizers and accepted only after a stable dwell. A complete four-digit frame is reported with a one-cycle valid pulse.

## Interface
- STABLE_CYCLES, 4, consecutive cycles a synchronized (an_n, seg_n) pair must hold before the digit is accepted; legal range 2..255
- clk  input  1  single system clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- seg_n  input  7  segment lines, active-low; bit0=a … bit6=g, encoding identical to the team's hex-to-segment encoder
- an_n  input  4  digit enables, active-low; an_n[0] = least significant digit
- value  output  16  last complete frame; digit k in value[4k+3:4k]
- value_valid  output  1  one-cycle pulse when value is updated
- digit_err  output  4  per-digit flag for the frame in value: pattern was not one of the 16 legal glyphs

## Operation
- seg_n and an_n each pass through a two-flop synchronizer; all logic below uses the synchronized copies.
- Dwell counter:
  - Clears to 0 when the synchronized pair differs from the previous cycle's pair, or when an_n is not one-hot-low (0 or ≥2 low bits).
  - Otherwise increments, saturating at STABLE_CYCLES.
- Accept event: counter reaches STABLE_CYCLES−1 while an_n is one-hot-low. It fires exactly once per dwell; a new dwell requires the pair to change.
- On accept for digit k:
  - Store the decoded nibble in frame buffer slot k.
  - Set seen[k].
  - Set err[k] if the pattern is illegal; an illegal pattern stores nibble 0.
  - The all-off pattern 7'h7F is illegal.
- Re-accepting a digit whose seen[k] is already set overwrites the slot (latest wins).
- When the accept makes seen == 4'hF, the next cycle does all of the following together:
  - value ← buffer, including the slot just written.
  - digit_err ← err.
  - value_valid = 1.
  - seen and err are cleared.
- value and digit_err hold between frames.
- Reset: value=0, value_valid=0, digit_err=0, seen=0, err=0, counter=0, synchronizer flops=1 (idle display).
- Reset asserted mid-frame discards the partial frame.
- States: IDLE (no accept pending), DWELL (counting), HELD (accepted, waiting for change). Transitions:
  - pair change or non-one-hot an_n → IDLE
  - one-hot stable → DWELL
  - accept → HELD

## Timing
- Input to accept: 2 synchronizer cycles + STABLE_CYCLES cycles of stability.
- Frame completion: value_valid rises 1 cycle after the fourth accept.
- value, digit_err and value_valid are registered outputs with no combinational path from inputs.
- Dwell shorter than STABLE_CYCLES is ignored entirely, including ghosting during anode transitions.
- Exactly STABLE_CYCLES is accepted.
- Counter saturation prevents wrap, so an indefinitely held digit is accepted once only.

## Structure
- Shared package seg7_pkg:
  - the 16 active-low glyph constants (0–9, A–F), shared with the encoder
  - a SEG_BLANK constant (7'h7F)
  - the digit count (4)
- Sub-module seg7_pattern_decode: purely combinational 7-bit pattern → {legal, nibble}, the inverse of the encoder table.
- The top level holds the synchronizers, dwell counter/FSM, frame buffer and output registers.

## Test plan
- Scan 1, 2, 3, 4 on digits 0..3, 8-cycle dwells each → value=16'h4321, value_valid pulses once, digit_err=0.
- Digit 2 driven with an_n=4'b1011, seg_n=7'h7F (blank) within the scan → digit_err=4'b0100, value[11:8]=0.
- 3-cycle dwell for digit 0 with STABLE_CYCLES=4, then a normal scan of A,B,C,D → glitch ignored, value=16'hDCBA.
- an_n=4'b1100 (two digits low) held 20 cycles → no accept, no value_valid.
- Digit 0 shown as 5 then re-scanned as 7 before digits 1–3 (values 0,0,0) → value=16'h0007.
- Reset after two digits accepted, then a full scan of F,E,D,C → no stale slots, value=16'hCDEF, one value_valid.
